// File: rtl/apb_arbiter.sv
// apb_arbiter: round-robin arbiter sharing one APB completer among NUM_REQ
// requesters, one transfer outstanding at a time (IDLE -> SETUP -> ACCESS).
// Optional ACCESS watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                 pclk,
  input  logic                                 presetn,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]                   req_write,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0][STRB_WIDTH-1:0]   req_strb,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [DATA_WIDTH-1:0]                rsp_rdata,
  output logic                                 rsp_err,
  output logic                                 psel,
  output logic                                 penable,
  output logic                                 pwrite,
  output logic [ADDR_WIDTH-1:0]                paddr,
  output logic [DATA_WIDTH-1:0]                pwdata,
  output logic [STRB_WIDTH-1:0]                pstrb,
  input  logic [DATA_WIDTH-1:0]                prdata,
  input  logic                                 pready,
  input  logic                                 pslverr
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] strb;
  } xfer_t;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     last_q, last_d, own_q, own_d, gnt_idx;
  logic                 gnt_found;
  xfer_t                xfer_q, xfer_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 timeout;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stalled-ACCESS counter, cleared whenever a new transfer is granted
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && gnt_found)       cnt_d = '0;
    else if (state_q == ACCESS && !pready)  cnt_d = cnt_q + CNT_W'(1);
  end

  // Fires in the last allowed stalled ACCESS cycle so psel drops right after it
  assign timeout = (state_q == ACCESS) && !pready &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counter register
  always_ff @(posedge pclk) begin
    if (!presetn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Round-robin search starting one past the last grant
  always_comb begin
    int cand;
    cand      = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid[IDX_W'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

  // FSM next state, accept pulse, field latch and response generation
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    own_d       = own_q;
    xfer_d      = xfer_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          // Masked while in reset so no accept is seen that would be discarded
          req_ready[gnt_idx] = presetn;
          state_d            = SETUP;
          last_d             = gnt_idx;
          own_d              = gnt_idx;
          xfer_d.addr        = req_addr[gnt_idx];
          xfer_d.write       = req_write[gnt_idx];
          // Reads present zero data and strobes on the bus
          xfer_d.wdata       = req_write[gnt_idx] ? req_wdata[gnt_idx] : '0;
          xfer_d.strb        = req_write[gnt_idx] ? req_strb[gnt_idx]  : '0;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          state_d            = IDLE;
          rsp_valid_d[own_q] = 1'b1;
          rsp_rdata_d        = xfer_q.write ? '0 : prdata;
          rsp_err_d          = pslverr;
        end else if (timeout) begin
          state_d            = IDLE;
          rsp_valid_d[own_q] = 1'b1;
          rsp_err_d          = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transfer silently
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(NUM_REQ - 1);
      own_q       <= '0;
      xfer_q      <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      own_q       <= own_d;
      xfer_q      <= xfer_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel      = (state_q != IDLE);
  assign penable   = (state_q == ACCESS);
  assign paddr     = xfer_q.addr;
  assign pwrite    = xfer_q.write;
  assign pwdata    = xfer_q.wdata;
  assign pstrb     = xfer_q.strb;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: directed scenarios plus randomized traffic, all checked
// against a transaction-level reference model of the arbiter.
module tb_apb_arbiter;
  localparam int NR  = 4;
  localparam int TMO = 16;
  localparam int M_HOLD = 0, M_KEEP = 1, M_RAND = 2;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic                presetn;
  logic [NR-1:0]       req_valid, req_ready, req_write, rsp_valid;
  logic [NR-1:0][31:0] req_addr, req_wdata;
  logic [NR-1:0][3:0]  req_strb;
  logic [31:0]         rsp_rdata, paddr, pwdata, prdata;
  logic [3:0]          pstrb;
  logic                rsp_err, psel, penable, pwrite, pready, pslverr;

  apb_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4),
                .TIMEOUT_CYCLES(TMO)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  int n_err, n_chk, cyc, acc, pen_cnt, obs_cyc;
  int g_id[$], g_cyc[$];
  logic [NR-1:0] obs_rv;
  logic [31:0]   obs_rdata;
  logic          obs_err;

  // reference model: one outstanding transfer, phase 1 = SETUP, >=2 = ACCESS
  bit          m_busy, m_write, m_err, m_rstd;
  int          m_own, m_ph, m_last, m_rsp;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_strb;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic m_reset();
    m_busy = 0; m_own = 0; m_ph = 0; m_last = NR - 1; m_rsp = -1;
    m_addr = '0; m_write = 0; m_wdata = '0; m_strb = '0;
    m_rdata = '0; m_err = 0; m_rstd = 1;
  endtask

  task automatic set_req(input int r, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_valid[r] = 1'b1; req_write[r] = wr; req_addr[r] = a;
    req_wdata[r] = d;    req_strb[r]  = s;
  endtask

  // one cycle: compare against model, then advance model across the edge
  task automatic step();
    int w;
    logic [NR-1:0] exp_rdy, exp_rv;
    #1;
    w = -1;
    if (presetn && !m_busy) w = pick(req_valid, m_last);
    exp_rdy = '0; if (w >= 0)     exp_rdy[w]     = 1'b1;
    exp_rv  = '0; if (m_rsp >= 0) exp_rv[m_rsp]  = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("rsp_valid", rsp_valid, exp_rv);
    if (m_rsp >= 0 || m_rstd) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", rsp_err, m_err);
    end
    chk("psel", psel, m_busy);
    chk("penable", penable, m_busy && m_ph >= 2);
    chk("paddr", paddr, m_addr);
    chk("pwrite", pwrite, m_write);
    chk("pwdata", pwdata, m_wdata);
    chk("pstrb", pstrb, m_strb);
    pen_cnt += int'(penable);
    if (rsp_valid != '0) begin
      obs_rv = rsp_valid; obs_rdata = rsp_rdata; obs_err = rsp_err; obs_cyc = cyc;
    end
    if (w >= 0) begin g_id.push_back(w); g_cyc.push_back(cyc); end
    acc = w;
    if (!presetn) m_reset();
    else begin
      m_rstd = 0; m_rsp = -1;
      if (m_busy && m_ph == 1) m_ph = 2;
      else if (m_busy) begin
        if (pready) begin
          m_rsp = m_own; m_rdata = m_write ? '0 : prdata; m_err = pslverr; m_busy = 0;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (m_ph - 1 == TMO) begin
          m_rsp = m_own; m_rdata = '0; m_err = 1; m_busy = 0;
        end
`endif
        else m_ph++;
      end else if (w >= 0) begin
        m_busy = 1; m_ph = 1; m_own = w; m_last = w;
        m_addr = req_addr[w]; m_write = req_write[w];
        m_wdata = m_write ? req_wdata[w] : '0;
        m_strb  = m_write ? req_strb[w]  : '0;
      end
    end
    cyc++;
    @(negedge pclk);
  endtask

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      if (mode == M_RAND) begin
        presetn = ($urandom_range(0, 149) != 0);
        pready  = ($urandom_range(0, 9) < 7);
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
        for (int r = 0; r < NR; r++) begin
          if (!req_valid[r] && $urandom_range(0, 2) == 0)
            set_req(r, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
          else if (req_valid[r] && $urandom_range(0, 19) == 0)
            req_valid[r] = 1'b0;
        end
      end
      step();
      if (acc >= 0 && mode != M_KEEP) req_valid[acc] = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_err = 0; n_chk = 0; cyc = 0; acc = -1; pen_cnt = 0; obs_cyc = 0;
    obs_rv = '0; obs_rdata = '0; obs_err = 0;
    presetn = 0; req_valid = '0; req_addr = '0; req_write = '0;
    req_wdata = '0; req_strb = '0; pready = 0; prdata = '0; pslverr = 0;
    m_reset();
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    run(1, M_HOLD);               // reset state: all outputs zero
    presetn = 1;

    // single write from requester 2, zero-wait completer
    set_req(2, 1, 32'h10, 32'hA5A5A5A5, 4'hF);
    pready = 1; prdata = 32'hDEADBEEF; pslverr = 0;
    g_id.delete(); g_cyc.delete(); obs_rv = '0;
    run(5, M_HOLD);
    chk("w_gnt_n", g_id.size(), 1);
    chk("w_gnt", g_id[0], 2);
    chk("w_rsp_id", obs_rv, 4'b0100);
    chk("w_rsp_lat", obs_cyc - g_cyc[0], 3);
    chk("w_rsp_err", obs_err, 0);

    // all four continuously valid after reset: 0,1,2,3,0 every 3 cycles
    presetn = 0; run(1, M_HOLD); presetn = 1;
    for (int r = 0; r < NR; r++) set_req(r, 1'(r % 2), 32'h100 + 32'(r * 4), $urandom, 4'hF);
    g_id.delete(); g_cyc.delete();
    run(13, M_KEEP);
    chk("rr_n", g_id.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk("rr_order", g_id[k], k % NR);
      chk("rr_gap", g_cyc[k] - g_cyc[0], 3 * k);
    end
    req_valid = '0; run(4, M_HOLD);

    // read with 3 wait states and slave error; wdata/strb must be zeroed
    set_req(1, 0, 32'h20, 32'hFFFFFFFF, 4'hF);
    pready = 0; prdata = 32'h12345678; pslverr = 1; obs_rv = '0;
    run(2, M_HOLD);
    pen_cnt = 0; run(3, M_HOLD); pready = 1; run(2, M_HOLD);
    chk("rd_pen", pen_cnt, 4);
    chk("rd_rsp_id", obs_rv, 4'b0010);
    chk("rd_rdata", obs_rdata, 32'h12345678);
    chk("rd_err", obs_err, 1);
    pslverr = 0;

    // reset during ACCESS: no response, next grant restarts at requester 0
    set_req(1, 1, 32'h44, 32'h55AA, 4'h3); pready = 0;
    run(3, M_HOLD);
    presetn = 0; obs_rv = '0; run(1, M_HOLD);
    presetn = 1; run(1, M_HOLD);
    chk("rst_norsp", obs_rv, 0);
    for (int r = 0; r < NR; r++) set_req(r, 1, 32'h200 + 32'(r), $urandom, 4'hF);
    g_id.delete(); g_cyc.delete();
    run(1, M_HOLD);
    chk("rst_gnt", g_id[0], 0);
    req_valid = '0; pready = 1; run(4, M_HOLD);

    // completer never ready for 20 ACCESS cycles
    set_req(3, 0, 32'h30, 32'h0, 4'h0);
    pready = 0; prdata = 32'hCAFE0000; obs_rv = '0;
    run(2, M_HOLD);
    pen_cnt = 0; run(20, M_HOLD); pready = 1; run(3, M_HOLD);
    chk("to_rsp_id", obs_rv, 4'b1000);
`ifdef APB_ARB_TIMEOUT_EN
    chk("to_pen", pen_cnt, TMO);
    chk("to_err", obs_err, 1);
    chk("to_rdata", obs_rdata, 0);
`else
    chk("to_pen", pen_cnt, 21);
    chk("to_err", obs_err, 0);
    chk("to_rdata", obs_rdata, 32'hCAFE0000);
`endif

    // randomized traffic with occasional resets
    run(3000, M_RAND);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the APB completer (2..8).
REQ-002 Parameter ADDR_WIDTH, default 32, APB address width.
REQ-003 Parameter DATA_WIDTH, default 32, APB data width.
REQ-004 Parameter STRB_WIDTH, default DATA_WIDTH/8, write strobe width.
REQ-005 Parameter TIMEOUT_CYCLES, default 16, watchdog limit in ACCESS cycles.
REQ-006 pclk  in  1  sole clock, all state on rising edge.
REQ-007 presetn  in  1  synchronous, active-low reset.
REQ-008 req_valid  in  NUM_REQ  per-requester transfer request, held until accepted.
REQ-009 req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
REQ-010 req_addr / req_write / req_wdata / req_strb  in  NUM_REQ x ADDR_WIDTH / NUM_REQ / NUM_REQ x DATA_WIDTH / NUM_REQ x STRB_WIDTH  packed per-requester fields, index i at slice i.
REQ-011 rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse to the owning requester.
REQ-012 rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
REQ-013 rsp_err  out  1  error flag, valid with rsp_valid.
REQ-014 psel, penable, pwrite  out  1 each  APB control.
REQ-015 paddr  out  ADDR_WIDTH;  pwdata  out  DATA_WIDTH;  pstrb  out  STRB_WIDTH.
REQ-016 prdata  in  DATA_WIDTH;  pready  in  1;  pslverr  in  1  completer response.

Function
REQ-017 FSM states SHALL be IDLE, SETUP and ACCESS; at most one transfer is outstanding.
REQ-018 IDLE with any req_valid high: grant winner g, pulse req_ready[g] in that cycle, latch g's fields, go SETUP.
REQ-019 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ; last_grant updates to g on each grant.
REQ-020 SETUP: psel=1, penable=0, paddr/pwrite/pwdata/pstrb = latched fields; next state ACCESS unconditionally.
REQ-021 ACCESS: psel=1, penable=1; all APB outputs stable; stay while pready=0.
REQ-022 ACCESS with pready=1: next cycle rsp_valid[g]=1, rsp_rdata=prdata (reads; 0 for writes), rsp_err=pslverr; FSM IDLE in that cycle.
REQ-023 The IDLE cycle carrying rsp_valid SHALL also be able to grant; minimum transfer period 3 cycles (grant, SETUP, ACCESS).
REQ-024 Reads SHALL drive pstrb=0 and pwdata=0.
REQ-025 In IDLE, psel=penable=0; paddr/pwrite/pwdata/pstrb hold the last transfer's values.
REQ-026 A requester dropping req_valid before accept is not served; requests arriving after the grant decision wait for the next IDLE cycle.
REQ-027 req_ready and rsp_valid SHALL never have more than one bit set.

Reset
REQ-028 presetn low at a rising edge SHALL force IDLE, last_grant=NUM_REQ-1, and all outputs to 0 at that edge.
REQ-029 Reset during SETUP/ACCESS SHALL abandon the transfer with no rsp_valid issued.
REQ-030 The first grant after reset with all requesters valid SHALL go to requester 0.

Configuration
REQ-031 Macro APB_ARB_TIMEOUT_EN defined: a counter clears on SETUP entry and counts ACCESS cycles with pready=0; on reaching TIMEOUT_CYCLES, next cycle psel=penable=0, FSM IDLE, rsp_valid[g]=1, rsp_err=1, rsp_rdata=0.
REQ-032 Macro undefined: no counter exists; ACCESS waits indefinitely for pready; TIMEOUT_CYCLES unused.

Verification
REQ-033 Req 2 write addr 0x10 data 0xA5A5A5A5 strb 0xF, pready=1 -> req_ready[2] cycle N, psel N+1, penable N+2, rsp_valid[2] N+3, rsp_err=0.
REQ-034 All 4 valid continuously after reset -> grant order 0,1,2,3,0; transfers 3 cycles apart.
REQ-035 Read addr 0x20, pready low 3 ACCESS cycles, prdata=0x12345678, pslverr=1 -> penable high 4 cycles, rsp_rdata=0x12345678, rsp_err=1.
REQ-036 presetn low in ACCESS of req 1 -> psel=penable=0 next edge, no rsp_valid; next grant to req 0.
REQ-037 APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready held 0 -> psel drops after 16 ACCESS cycles, rsp_valid with rsp_err=1, rsp_rdata=0.
